// File: rtl/lcd_timing_gen.sv
// Pixel-domain video timing generator for the parallel RGB LCD.
// Issues frame-buffer fetch requests and emits DE/HS/VS delayed to meet the returned pixel data.
module lcd_timing_gen #(
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 40,
    parameter int   H_SYNC   = 128,
    parameter int   H_BP     = 88,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 13,
    parameter int   V_SYNC   = 3,
    parameter int   V_BP     = 32,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   DATA_LAT = 2,
    parameter int   HW       = 11,
    parameter int   VW       = 10
) (
    input  logic          clkin,
    input  logic          resetn,
    input  logic          en,
    output logic          busy,
    output logic          req,
    output logic [HW-1:0] req_x,
    output logic [VW-1:0] req_y,
    output logic          frame_start,
    output logic          lcd_de,
    output logic          lcd_hs,
    output logic          lcd_vs
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL - 1 >= (1 << HW)) begin : g_bad_hw
        $error("lcd_timing_gen: H_TOTAL-1 does not fit in HW bits");
    end
    if (V_TOTAL - 1 >= (1 << VW)) begin : g_bad_vw
        $error("lcd_timing_gen: V_TOTAL-1 does not fit in VW bits");
    end
    if (DATA_LAT < 0 || DATA_LAT > 15) begin : g_bad_lat
        $error("lcd_timing_gen: DATA_LAT outside 0..15");
    end

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // Delay-line entry layout: {de, hs, vs}, sync levels already polarity-adjusted
    localparam logic [2:0] INACTIVE = {1'b0, ~HS_POL, ~VS_POL};

    logic [0:0]    state, state_n;
    logic [HW-1:0] hcnt, hcnt_n;
    logic [VW-1:0] vcnt, vcnt_n;
    logic          run_n, req_n, hs_n, vs_n;
    logic          hs_lvl, vs_lvl;
    logic [2:0]    pipe [0:DATA_LAT];

    // Request-stage outputs are computed from the next counter values so that
    // req/req_x/req_y line up with the clock in which the counters hold them.
    always_comb begin
        state_n = state;
        hcnt_n  = hcnt;
        vcnt_n  = vcnt;
        case (state)
            IDLE: begin
                hcnt_n = '0;
                vcnt_n = '0;
                if (en) state_n = RUN;
            end
            default: begin
                if (hcnt == H_LAST) begin
                    hcnt_n = '0;
                    if (vcnt == V_LAST) begin
                        vcnt_n = '0;
                        if (!en) state_n = IDLE;
                    end else begin
                        vcnt_n = vcnt + 1'b1;
                    end
                end else begin
                    hcnt_n = hcnt + 1'b1;
                end
            end
        endcase

        run_n  = (state_n == RUN);
        req_n  = run_n && (int'(hcnt_n) < H_ACTIVE) && (int'(vcnt_n) < V_ACTIVE);
        hs_n   = run_n && (int'(hcnt_n) >= H_ACTIVE + H_FP)
                       && (int'(hcnt_n) <  H_ACTIVE + H_FP + H_SYNC);
        vs_n   = run_n && (int'(vcnt_n) >= V_ACTIVE + V_FP)
                       && (int'(vcnt_n) <  V_ACTIVE + V_FP + V_SYNC);
        hs_lvl = hs_n ? HS_POL : ~HS_POL;
        vs_lvl = vs_n ? VS_POL : ~VS_POL;
    end

    always_ff @(posedge clkin) begin
        if (!resetn) begin
            state       <= IDLE;
            hcnt        <= '0;
            vcnt        <= '0;
            req_x       <= '0;
            req_y       <= '0;
            frame_start <= 1'b0;
            for (int i = 0; i <= DATA_LAT; i++) pipe[i] <= INACTIVE;
        end else begin
            state       <= state_n;
            hcnt        <= hcnt_n;
            vcnt        <= vcnt_n;
            frame_start <= req_n && (hcnt_n == '0) && (vcnt_n == '0);
            if (req_n) begin
                req_x <= hcnt_n;
                req_y <= vcnt_n;
            end
            pipe[0] <= {req_n, hs_lvl, vs_lvl};
            for (int i = 1; i <= DATA_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    // Stage 0 is the request stage itself, so DATA_LAT=0 adds no extra register
    assign busy   = (state == RUN);
    assign req    = pipe[0][2];
    assign lcd_de = pipe[DATA_LAT][2];
    assign lcd_hs = pipe[DATA_LAT][1];
    assign lcd_vs = pipe[DATA_LAT][0];

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen on a tiny 8x6 raster: instance a (lat 2, active-low syncs),
// b (lat 0) and c (lat 15) with active-high syncs, all sharing clock, reset and enable.
module tb_lcd_timing_gen;

    localparam int HT = 8;
    localparam int VT = 6;
    localparam int FR = HT * VT;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic en = 1'b0;

    logic       a_busy, a_req, a_fs, a_de, a_hs, a_vs;
    logic [3:0] a_x;
    logic [2:0] a_y;
    logic       b_busy, b_req, b_fs, b_de, b_hs, b_vs;
    logic [3:0] b_x;
    logic [2:0] b_y;
    logic       c_busy, c_req, c_fs, c_de, c_hs, c_vs;
    logic [3:0] c_x;
    logic [2:0] c_y;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    lcd_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .HS_POL(1'b0), .VS_POL(1'b0), .DATA_LAT(2), .HW(4), .VW(3)) dut_a (
        .clkin(clk), .resetn(resetn), .en(en), .busy(a_busy), .req(a_req),
        .req_x(a_x), .req_y(a_y), .frame_start(a_fs),
        .lcd_de(a_de), .lcd_hs(a_hs), .lcd_vs(a_vs));

    lcd_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .HS_POL(1'b1), .VS_POL(1'b1), .DATA_LAT(0), .HW(4), .VW(3)) dut_b (
        .clkin(clk), .resetn(resetn), .en(en), .busy(b_busy), .req(b_req),
        .req_x(b_x), .req_y(b_y), .frame_start(b_fs),
        .lcd_de(b_de), .lcd_hs(b_hs), .lcd_vs(b_vs));

    lcd_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .HS_POL(1'b1), .VS_POL(1'b1), .DATA_LAT(15), .HW(4), .VW(3)) dut_c (
        .clkin(clk), .resetn(resetn), .en(en), .busy(c_busy), .req(c_req),
        .req_x(c_x), .req_y(c_y), .frame_start(c_fs),
        .lcd_de(c_de), .lcd_hs(c_hs), .lcd_vs(c_vs));

    // k counts clocks since the first RUN clock; outside [0, nfr frames) nothing is active
    function automatic logic m_req(int k, int nfr);
        if (k < 0 || k >= FR * nfr) return 1'b0;
        return ((k % HT) < 4) && (((k / HT) % VT) < 3);
    endfunction

    function automatic logic m_hs(int k, int nfr);
        if (k < 0 || k >= FR * nfr) return 1'b0;
        return ((k % HT) >= 5) && ((k % HT) < 7);
    endfunction

    function automatic logic m_vs(int k, int nfr);
        if (k < 0 || k >= FR * nfr) return 1'b0;
        return ((k / HT) % VT) == 4;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        en     = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        en     = 1'b0;
        repeat (2) tick();
        nvec++;
        if ({a_req, a_fs, a_busy, a_de, a_hs, a_vs} !== 6'b000011) begin
            nerr++;
            $display("FAIL reset_a got %b want 000011", {a_req, a_fs, a_busy, a_de, a_hs, a_vs});
        end
        nvec++;
        if ({a_x, a_y} !== 7'd0) begin
            nerr++;
            $display("FAIL reset_xy got x=%0d y=%0d want 0/0", a_x, a_y);
        end
        nvec++;
        if ({b_de, b_hs, b_vs} !== 3'b000) begin
            nerr++;
            $display("FAIL reset_b got %b want 000", {b_de, b_hs, b_vs});
        end
        nvec++;
        if ({c_de, c_hs, c_vs} !== 3'b000) begin
            nerr++;
            $display("FAIL reset_c got %b want 000", {c_de, c_hs, c_vs});
        end
        resetn = 1'b1;
        repeat (3) tick();
        nvec++;
        if ({a_req, a_busy, a_de, a_hs, a_vs} !== 5'b00011) begin
            nerr++;
            $display("FAIL idle_a got %b want 00011", {a_req, a_busy, a_de, a_hs, a_vs});
        end
    endtask

    task automatic test_continuous();
        logic [5:0] exp;
        do_reset();
        en = 1'b1;
        tick();
        for (int k = 0; k < 2 * FR + 4; k++) begin
            exp = {m_req(k, 100), (k % FR) == 0, 1'b1,
                   m_req(k - 2, 100), ~m_hs(k - 2, 100), ~m_vs(k - 2, 100)};
            nvec++;
            if ({a_req, a_fs, a_busy, a_de, a_hs, a_vs} !== exp) begin
                nerr++;
                $display("FAIL cont k=%0d got %b want %b", k,
                         {a_req, a_fs, a_busy, a_de, a_hs, a_vs}, exp);
            end
            if (m_req(k, 100)) begin
                nvec++;
                if (a_x !== 4'(k % HT) || a_y !== 3'((k / HT) % VT)) begin
                    nerr++;
                    $display("FAIL cont_xy k=%0d got %0d/%0d want %0d/%0d", k, a_x, a_y,
                             k % HT, (k / HT) % VT);
                end
            end
            tick();
        end
    endtask

    task automatic test_single_frame();
        logic [5:0] exp;
        do_reset();
        en = 1'b1;
        tick();
        en = 1'b0;
        for (int k = 0; k < FR + 20; k++) begin
            exp = {m_req(k, 1), k == 0, k < FR,
                   m_req(k - 2, 1), ~m_hs(k - 2, 1), ~m_vs(k - 2, 1)};
            nvec++;
            if ({a_req, a_fs, a_busy, a_de, a_hs, a_vs} !== exp) begin
                nerr++;
                $display("FAIL single k=%0d got %b want %b", k,
                         {a_req, a_fs, a_busy, a_de, a_hs, a_vs}, exp);
            end
            tick();
        end
        nvec++;
        if (a_x !== 4'd3 || a_y !== 3'd2) begin
            nerr++;
            $display("FAIL single_hold got %0d/%0d want 3/2", a_x, a_y);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        en = 1'b1;
        tick();
        for (int k = 0; k < FR + 12; k++) begin
            nvec++;
            if ({a_busy, a_fs, a_req} !== {1'b1, (k % FR) == 0, m_req(k, 2)}) begin
                nerr++;
                $display("FAIL b2b k=%0d got %b want %b", k, {a_busy, a_fs, a_req},
                         {1'b1, (k % FR) == 0, m_req(k, 2)});
            end
            if (k == 8)  en = 1'b0;
            if (k == 40) en = 1'b1;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 1'b1;
        tick();
        repeat (23) tick();
        nvec++;
        if ({a_de, a_hs, a_vs} !== 3'b001 || {a_x, a_y} !== {4'd3, 3'd2}) begin
            nerr++;
            $display("FAIL pre_rst got %b x=%0d y=%0d want 001 x=3 y=2",
                     {a_de, a_hs, a_vs}, a_x, a_y);
        end
        resetn = 1'b0;
        tick();
        nvec++;
        if ({a_req, a_fs, a_busy, a_de, a_hs, a_vs} !== 6'b000011 || {a_x, a_y} !== 7'd0) begin
            nerr++;
            $display("FAIL mid_rst got %b x=%0d y=%0d want 000011 x=0 y=0",
                     {a_req, a_fs, a_busy, a_de, a_hs, a_vs}, a_x, a_y);
        end
        nvec++;
        if ({b_de, b_hs, b_vs, c_de, c_hs, c_vs} !== 6'b000000) begin
            nerr++;
            $display("FAIL mid_rst_bc got %b want 000000", {b_de, b_hs, b_vs, c_de, c_hs, c_vs});
        end
        resetn = 1'b1;
        tick();
        nvec++;
        if ({a_req, a_fs, a_busy, a_de, a_hs, a_vs} !== 6'b111011 || {a_x, a_y} !== 7'd0) begin
            nerr++;
            $display("FAIL restart got %b x=%0d y=%0d want 111011 x=0 y=0",
                     {a_req, a_fs, a_busy, a_de, a_hs, a_vs}, a_x, a_y);
        end
    endtask

    task automatic test_latency();
        do_reset();
        en = 1'b1;
        tick();
        en = 1'b0;
        for (int k = 0; k < FR + 20; k++) begin
            nvec++;
            if ({b_de, b_hs, b_vs} !== {m_req(k, 1), m_hs(k, 1), m_vs(k, 1)}) begin
                nerr++;
                $display("FAIL lat0 k=%0d got %b want %b", k, {b_de, b_hs, b_vs},
                         {m_req(k, 1), m_hs(k, 1), m_vs(k, 1)});
            end
            nvec++;
            if ({c_de, c_hs, c_vs} !== {m_req(k - 15, 1), m_hs(k - 15, 1), m_vs(k - 15, 1)}) begin
                nerr++;
                $display("FAIL lat15 k=%0d got %b want %b", k, {c_de, c_hs, c_vs},
                         {m_req(k - 15, 1), m_hs(k - 15, 1), m_vs(k - 15, 1)});
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_single_frame();
        test_back_to_back();
        test_reset_mid();
        test_latency();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
